// File: rtl/shift16_pkg.sv
// rtl/shift16_pkg.sv - shared types and constants for the 16-bit sequenced shifter
package shift16_pkg;

  localparam int LANE_W = 8;
  localparam int WORD_W = 16;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PA,
    PB,
    PC,
    DONE
  } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational 8-bit logical shifter lane
module barrel_shifter
  import shift16_pkg::*;
(
  input  logic [LANE_W-1:0] inp,
  input  logic [2:0]        shamt,
  input  logic              dir,
  output logic [LANE_W-1:0] out
);

  always_comb begin
    if (dir == DIR_LEFT) out = inp << shamt;
    else                 out = inp >> shamt;
  end

endmodule

// File: rtl/shift16_seq.sv
// rtl/shift16_seq.sv - 16-bit logical shift built from up to three passes of one 8-bit lane
module shift16_seq
  import shift16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  input  logic [3:0]        shamt,
  input  logic              dir,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
);

  state_t state, next_state;

  logic [LANE_W-1:0] hi, lo, acc;
  logic [3:0]        k;
  logic              d;

  logic [LANE_W-1:0] sh_inp, sh_out;
  logic [2:0]        sh_amt;
  logic              sh_dir;

  barrel_shifter u_lane (
    .inp   (sh_inp),
    .shamt (sh_amt),
    .dir   (sh_dir),
    .out   (sh_out)
  );

  // Lane drive depends on registered state only, so each pass is one reg-to-reg path.
  always_comb begin
    next_state = state;
    sh_inp     = lo;
    sh_amt     = k[2:0];
    sh_dir     = d;
    case (state)
      IDLE: begin
        if (start) next_state = (shamt == 4'd0) ? DONE : PA;
      end
      PA: begin
        if (k[3]) begin
          sh_inp     = (d == DIR_LEFT) ? lo : hi;
          next_state = DONE;
        end else begin
          sh_inp     = (d == DIR_LEFT) ? hi : lo;
          next_state = PB;
        end
      end
      PB: begin
        // Bits crossing the byte boundary: opposite direction by 8-k (== -k mod 8).
        sh_inp     = (d == DIR_LEFT) ? lo : hi;
        sh_amt     = 3'd0 - k[2:0];
        sh_dir     = ~d;
        next_state = PC;
      end
      PC: begin
        sh_inp     = (d == DIR_LEFT) ? lo : hi;
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      k      <= '0;
      d      <= DIR_RIGHT;
      result <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            hi <= data[15:8];
            lo <= data[7:0];
            k  <= shamt;
            d  <= dir;
            if (shamt == 4'd0) result <= data;
          end
        end
        PA: begin
          if (k[3]) begin
            result <= (d == DIR_LEFT) ? {sh_out, 8'h00} : {8'h00, sh_out};
          end else begin
            acc <= sh_out;
          end
        end
        PB: begin
          acc <= acc | sh_out;
        end
        PC: begin
          result <= (d == DIR_LEFT) ? {acc, sh_out} : {sh_out, acc};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift16_seq.sv
// tb/tb_shift16_seq.sv - self-checking bench for shift16_seq
module tb_shift16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data;
  logic [3:0]  shamt;
  logic        dir;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  shift16_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data   (data),
    .shamt  (shamt),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_result(input logic [15:0] dt, input logic [3:0] sa, input logic dr);
    logic [31:0] w;
    w = {16'h0, dt};
    if (dr) w = w << sa;
    else    w = w >> sa;
    return w[15:0];
  endfunction

  function automatic int model_latency(input logic [3:0] sa);
    if (sa == 4'd0) return 1;
    if (sa >= 4'd8) return 2;
    return 4;
  endfunction

  // Issues one op from idle and watches 8 cycles after the accept edge.
  task automatic do_op(input logic [15:0] dt, input logic [3:0] sa, input logic dr,
                       output logic [15:0] res, output int lat, output int pulses);
    start = 1'b1; data = dt; shamt = sa; dir = dr;
    @(posedge clk); #1;
    start = 1'b0; data = $urandom; shamt = 4'($urandom); dir = 1'($urandom);
    lat = 0; pulses = 0; res = 16'hxxxx;
    for (int i = 1; i <= 8; i++) begin
      if (done) begin
        pulses++;
        if (lat == 0) begin lat = i; res = result; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data = 16'h0; shamt = 4'h0; dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] vd [5] = '{16'h1234, 16'hA5F0, 16'hBEEF, 16'h8001, 16'h0001};
    logic [3:0]  vs [5] = '{4'd4, 4'd12, 4'd0, 4'd1, 4'd15};
    logic        vr [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] res;
    int lat, pulses;
    for (int i = 0; i < 5; i++) begin
      do_op(vd[i], vs[i], vr[i], res, lat, pulses);
      checks++; if (res !== model_result(vd[i], vs[i], vr[i])) begin errors++;
        $display("FAIL directed_result[%0d] got %h want %h", i, res, model_result(vd[i], vs[i], vr[i])); end
      checks++; if (lat != model_latency(vs[i])) begin errors++;
        $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, model_latency(vs[i])); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL directed_pulses[%0d] got %0d want 1", i, pulses); end
      checks++; if (result !== model_result(vd[i], vs[i], vr[i])) begin errors++;
        $display("FAIL directed_hold[%0d] got %h want %h", i, result, model_result(vd[i], vs[i], vr[i])); end
    end
  endtask

  task automatic test_random();
    logic [15:0] dt, res;
    logic [3:0]  sa;
    logic        dr;
    int lat, pulses;
    for (int i = 0; i < 40; i++) begin
      dt = 16'($urandom); sa = 4'($urandom); dr = 1'($urandom);
      do_op(dt, sa, dr, res, lat, pulses);
      checks++; if (res !== model_result(dt, sa, dr) || lat != model_latency(sa) || pulses != 1) begin
        errors++;
        $display("FAIL random[%0d] d=%h k=%0d dir=%b got res=%h lat=%0d pulses=%0d want res=%h lat=%0d pulses=1",
                 i, dt, sa, dr, res, lat, pulses, model_result(dt, sa, dr), model_latency(sa));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] first_res;
    int lat, pulses;
    logic [15:0] res2;
    int lat2, pulses2;
    start = 1'b1; data = 16'h1234; shamt = 4'd4; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; pulses = 0; first_res = 16'hxxxx;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) begin start = 1'b1; data = 16'hFFFF; shamt = 4'd1; dir = 1'b0; end
      if (i == 3) start = 1'b0;
      if (done) begin
        pulses++;
        if (lat == 0) begin lat = i; first_res = result; end
      end
      @(posedge clk); #1;
    end
    checks++; if (first_res !== 16'h2340) begin errors++; $display("FAIL ignore_result got %h want 2340", first_res); end
    checks++; if (lat != 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_not_queued pulses got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle busy got %b want 0", busy); end
    do_op(16'hFFFF, 4'd1, 1'b0, res2, lat2, pulses2);
    checks++; if (res2 !== model_result(16'hFFFF, 4'd1, 1'b0) || lat2 != 4) begin errors++;
      $display("FAIL ignore_second got res=%h lat=%0d want res=%h lat=4", res2, lat2, model_result(16'hFFFF, 4'd1, 1'b0)); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    logic [15:0] res;
    int lat, p2;
    start = 1'b1; data = 16'hC3A5; shamt = 4'd5; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_pa busy got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL abort_result got %h want 0000", result); end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
    do_op(16'h0F0F, 4'd3, 1'b0, res, lat, p2);
    checks++; if (res !== model_result(16'h0F0F, 4'd3, 1'b0) || lat != 4 || p2 != 1) begin errors++;
      $display("FAIL abort_fresh got res=%h lat=%0d pulses=%0d want res=%h lat=4 pulses=1",
               res, lat, p2, model_result(16'h0F0F, 4'd3, 1'b0)); end
  endtask

  // start held high: ops issue every latency+1 cycles.
  task automatic test_back_to_back();
    logic [3:0] sas [3] = '{4'd3, 4'd9, 4'd0};
    int per, bad;
    for (int t = 0; t < 3; t++) begin
      per = model_latency(sas[t]) + 1;
      bad = 0;
      start = 1'b1; data = 16'h6B2D; shamt = sas[t]; dir = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 4 * per; i++) begin
        if (done !== ((i % per) == per - 1)) bad++;
        if (done && result !== model_result(16'h6B2D, sas[t], 1'b1)) bad++;
        if (i == 4 * per - 1) start = 1'b0;
        @(posedge clk); #1;
      end
      checks++; if (bad != 0) begin errors++;
        $display("FAIL back_to_back[k=%0d] got %0d bad cycles want 0", sas[t], bad); end
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
